// File: rtl/fixed_res_add_sat.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : fixed_res_add_sat                                             |
// | Description : Residual adder. Buffers skip beats, aligns both operands to   |
// |               the output Q-format, then applies the selected operation and  |
// |               saturates or wraps the result.                                |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module fixed_res_add_sat #(
    parameter int IN_WIDTH          = 8,
    parameter int IN_FRAC_WIDTH     = 4,
    parameter int MODULE_WIDTH      = 8,
    parameter int MODULE_FRAC_WIDTH = 3,
    parameter int OUT_WIDTH         = 8,
    parameter int OUT_FRAC_WIDTH    = 3,
    parameter int UNROLL_IN_SIZE    = 4,
    parameter int DEPTH             = 8,
    parameter int SATURATE          = 1,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [1:0]                             mode,
    input  logic [IN_WIDTH*UNROLL_IN_SIZE-1:0]     data_in,
    input  logic                                   data_in_valid,
    output logic                                   data_in_ready,
    input  logic [MODULE_WIDTH*UNROLL_IN_SIZE-1:0] module_in,
    input  logic                                   module_in_valid,
    output logic                                   module_in_ready,
    output logic [OUT_WIDTH*UNROLL_IN_SIZE-1:0]    data_out,
    output logic                                   data_out_valid,
    input  logic                                   data_out_ready,
    output logic [$clog2(DEPTH):0]                 fifo_count,
    output logic [CNT_WIDTH-1:0]                   sat_count
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_IN_BUS  = IN_WIDTH * UNROLL_IN_SIZE;
    localparam int c_OUT_BUS = OUT_WIDTH * UNROLL_IN_SIZE;

    localparam int c_A_SHL = (OUT_FRAC_WIDTH > IN_FRAC_WIDTH) ? OUT_FRAC_WIDTH - IN_FRAC_WIDTH : 0;
    localparam int c_A_SHR = (IN_FRAC_WIDTH > OUT_FRAC_WIDTH) ? IN_FRAC_WIDTH - OUT_FRAC_WIDTH : 0;
    localparam int c_M_SHL = (OUT_FRAC_WIDTH > MODULE_FRAC_WIDTH) ? OUT_FRAC_WIDTH - MODULE_FRAC_WIDTH : 0;
    localparam int c_M_SHR = (MODULE_FRAC_WIDTH > OUT_FRAC_WIDTH) ? MODULE_FRAC_WIDTH - OUT_FRAC_WIDTH : 0;

    // One spare bit per operand absorbs the rounding increment; two more make add/sub overflow-free.
    localparam int c_A_W   = IN_WIDTH + c_A_SHL + 1;
    localparam int c_M_W   = MODULE_WIDTH + c_M_SHL + 1;
    localparam int c_AM_W  = (c_A_W > c_M_W) ? c_A_W : c_M_W;
    localparam int c_W     = ((c_AM_W > OUT_WIDTH) ? c_AM_W : OUT_WIDTH) + 2;

    localparam logic [1:0]         c_MODE_ADD  = 2'd0;
    localparam logic [1:0]         c_MODE_SUB  = 2'd1;
    localparam logic [1:0]         c_MODE_SKIP = 2'd2;
    localparam logic [c_PTR_W:0]   c_FULL_CNT  = (c_PTR_W + 1)'(DEPTH);

    logic [c_IN_BUS-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [c_OUT_BUS-1:0] r_data_out;
    logic                 r_data_out_valid;
    logic [CNT_WIDTH-1:0] r_sat_count;

    logic                      w_full;
    logic                      w_nonempty;
    logic                      w_in_ready;
    logic                      w_slot_free;
    logic                      w_push;
    logic                      w_fire;
    logic [c_IN_BUS-1:0]       w_rd_data;
    logic [c_OUT_BUS-1:0]      w_result_bus;
    logic [UNROLL_IN_SIZE-1:0] w_clamp_vec;

    // Handshake decode: a full FIFO refuses a push even if a pop occurs in the same cycle.
    assign w_full      = (r_count == c_FULL_CNT);
    assign w_nonempty  = (r_count != '0);
    assign w_in_ready  = !rst && !w_full;
    assign w_slot_free = !r_data_out_valid || data_out_ready;
    assign w_push      = data_in_valid && w_in_ready;
    assign w_fire      = !rst && w_nonempty && module_in_valid && w_slot_free;
    assign w_rd_data   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    for (genvar i = 0; i < UNROLL_IN_SIZE; i++) begin : g_lane
        logic [IN_WIDTH-1:0]     w_a_raw;
        logic [MODULE_WIDTH-1:0] w_m_raw;
        logic signed [c_W-1:0]   w_a_ext;
        logic signed [c_W-1:0]   w_m_ext;
        logic signed [c_W-1:0]   w_a_al;
        logic signed [c_W-1:0]   w_m_al;
        logic signed [c_W-1:0]   w_res;
        logic [OUT_WIDTH-1:0]    w_narrow;
        logic                    w_clamp;

        assign w_a_raw = w_rd_data[i*IN_WIDTH +: IN_WIDTH];
        assign w_m_raw = module_in[i*MODULE_WIDTH +: MODULE_WIDTH];
        assign w_a_ext = {{(c_W-IN_WIDTH){w_a_raw[IN_WIDTH-1]}}, w_a_raw};
        assign w_m_ext = {{(c_W-MODULE_WIDTH){w_m_raw[MODULE_WIDTH-1]}}, w_m_raw};

        if (c_A_SHR > 0) begin : g_a_round
            localparam logic signed [c_W-1:0] c_A_HALF = {{(c_W-1){1'b0}}, 1'b1} <<< (c_A_SHR - 1);
            assign w_a_al = (w_a_ext + c_A_HALF) >>> c_A_SHR;
        end else begin : g_a_shift
            assign w_a_al = w_a_ext <<< c_A_SHL;
        end

        if (c_M_SHR > 0) begin : g_m_round
            localparam logic signed [c_W-1:0] c_M_HALF = {{(c_W-1){1'b0}}, 1'b1} <<< (c_M_SHR - 1);
            assign w_m_al = (w_m_ext + c_M_HALF) >>> c_M_SHR;
        end else begin : g_m_shift
            assign w_m_al = w_m_ext <<< c_M_SHL;
        end

        always_comb begin
            case (mode)
                c_MODE_ADD:  w_res = w_a_al + w_m_al;
                c_MODE_SUB:  w_res = w_a_al - w_m_al;
                c_MODE_SKIP: w_res = w_a_al;
                default:     w_res = w_m_al;
            endcase
        end

        if (SATURATE != 0) begin : g_sat
            localparam logic signed [c_W-1:0] c_MAX = {{(c_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
            localparam logic signed [c_W-1:0] c_MIN = {{(c_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
            always_comb begin
                w_narrow = w_res[OUT_WIDTH-1:0];
                w_clamp  = 1'b0;
                if (w_res > c_MAX) begin
                    w_narrow = c_MAX[OUT_WIDTH-1:0];
                    w_clamp  = 1'b1;
                end else if (w_res < c_MIN) begin
                    w_narrow = c_MIN[OUT_WIDTH-1:0];
                    w_clamp  = 1'b1;
                end
            end
        end else begin : g_wrap
            assign w_narrow = w_res[OUT_WIDTH-1:0];
            assign w_clamp  = 1'b0;
        end

        assign w_result_bus[i*OUT_WIDTH +: OUT_WIDTH] = w_narrow;
        assign w_clamp_vec[i]                         = w_clamp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
            r_sat_count      <= '0;
        end else begin
            if (w_fire) begin
                r_data_out       <= w_result_bus;
                r_data_out_valid <= 1'b1;
                if ((|w_clamp_vec) && (r_sat_count != {CNT_WIDTH{1'b1}})) begin
                    r_sat_count <= r_sat_count + 1'b1;
                end
            end else if (data_out_ready) begin
                r_data_out_valid <= 1'b0;
            end
        end
    end

    assign data_in_ready   = w_in_ready;
    assign module_in_ready = !rst && w_nonempty && w_slot_free;
    assign data_out        = r_data_out;
    assign data_out_valid  = r_data_out_valid;
    assign fifo_count      = r_count;
    assign sat_count       = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_fixed_res_add_sat.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_fixed_res_add_sat                                          |
// | Description : Directed bench for fixed_res_add_sat (saturating + wrapping). |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module tb_fixed_res_add_sat;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [31:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic [31:0] module_in = '0;
    logic        module_in_valid = 1'b0;
    logic        data_out_ready = 1'b1;

    logic [31:0] data_out, data_out_w;
    logic        data_out_valid, data_out_valid_w;
    logic        data_in_ready, data_in_ready_w;
    logic        module_in_ready, module_in_ready_w;
    logic [3:0]  fifo_count, fifo_count_w;
    logic [15:0] sat_count, sat_count_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fixed_res_add_sat #(.SATURATE(1)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .module_in(module_in), .module_in_valid(module_in_valid), .module_in_ready(module_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .fifo_count(fifo_count), .sat_count(sat_count)
    );

    fixed_res_add_sat #(.SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .mode(mode),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready_w),
        .module_in(module_in), .module_in_valid(module_in_valid), .module_in_ready(module_in_ready_w),
        .data_out(data_out_w), .data_out_valid(data_out_valid_w), .data_out_ready(data_out_ready),
        .fifo_count(fifo_count_w), .sat_count(sat_count_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Skip lane = 2*s in Q.4 (aligns exactly to s in Q.3); module lane = m in Q.3.
    function automatic logic [31:0] skip_word(input int b);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[j*8 +: 8] = 8'(2 * (((b*4 + j) % 60) - 30));
        return r;
    endfunction

    function automatic logic [31:0] mod_word(input int b);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[j*8 +: 8] = 8'(((b + j) % 40) - 20);
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input int b, input logic [1:0] md);
        logic [31:0] r;
        int s, m;
        for (int j = 0; j < 4; j++) begin
            s = ((b*4 + j) % 60) - 30;
            m = ((b + j) % 40) - 20;
            r[j*8 +: 8] = 8'((md == 2'd2) ? s : s + m);
        end
        return r;
    endfunction

    // Push one skip beat, then fire one module beat; returns at edge+1 after fire.
    task automatic do_pair(input logic [31:0] skip, input logic [31:0] modv, input logic [1:0] md);
        data_in       = skip;
        data_in_valid = 1'b1;
        step();
        data_in_valid   = 1'b0;
        module_in       = modv;
        module_in_valid = 1'b1;
        mode            = md;
        #1;
        chk("pre_fire_mir", 32'(module_in_ready), 32'd1);
        chk("pre_fire_valid", 32'(data_out_valid), 32'd0);
        step();
        module_in_valid = 1'b0;
        chk("post_fire_valid", 32'(data_out_valid), 32'd1);
    endtask

    task automatic run_stream(input int n, input logic [1:0] md, input bit rand_rdy, input int mod_delay);
        int pi = 0, mi = 0, q = 0, cyc = 0;
        bit pushed, popped, prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        while (q < n && cyc < 3000) begin
            data_in         = skip_word(pi);
            data_in_valid   = (pi < n);
            module_in       = mod_word(mi);
            module_in_valid = (mi < n) && (cyc >= mod_delay);
            mode            = md;
            data_out_ready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) begin
                chk("stall_valid", 32'(data_out_valid), 32'd1);
                chk("stall_data", data_out, prev_data);
            end
            if (data_out_valid && !data_out_ready)
                chk("busy_mir", 32'(module_in_ready), 32'd0);
            if (mod_delay >= 10 && cyc == mod_delay - 1) begin
                chk("full_count", 32'(fifo_count), 32'd8);
                chk("full_ready", 32'(data_in_ready), 32'd0);
            end
            if (data_out_valid && data_out_ready) begin
                chk($sformatf("stream_beat%0d", q), data_out, exp_word(q, md));
                q++;
            end
            pushed     = data_in_valid && data_in_ready;
            popped     = module_in_valid && module_in_ready;
            prev_stall = data_out_valid && !data_out_ready;
            prev_data  = data_out;
            step();
            pi  += int'(pushed);
            mi  += int'(popped);
            cyc++;
        end
        chk("stream_done", 32'(q), 32'(n));
        data_in_valid   = 1'b0;
        module_in_valid = 1'b0;
        data_out_ready  = 1'b1;
        step();
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_valid", 32'(data_out_valid), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_fifo", 32'(fifo_count), 32'd0);
        chk("rst_sat", 32'(sat_count), 32'd0);
        chk("rst_in_ready", 32'(data_in_ready), 32'd0);
        chk("rst_mir", 32'(module_in_ready), 32'd0);
        chk("rst_valid_w", 32'(data_out_valid_w), 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(data_in_ready), 32'd1);
        chk("in_ready_after_rst_w", 32'(data_in_ready_w), 32'd1);
        step();

        // T1: per-lane add, includes -3 (Q.4) rounding to -1 (Q.3)
        do_pair({8'h08, 8'hFD, 8'h10, 8'h18}, {8'h08, 8'h00, 8'h04, 8'h0C}, 2'd0);
        chk("t1_data", data_out, {8'h0C, 8'hFF, 8'h0C, 8'h18});
        chk("t1_data_w", data_out_w, {8'h0C, 8'hFF, 8'h0C, 8'h18});
        chk("t1_sat", 32'(sat_count), 32'd0);

        // T2: saturation vs wrap
        do_pair(32'h7F7F7F7F, 32'h7F7F7F7F, 2'd0);
        chk("t2_pos_sat", data_out, 32'h7F7F7F7F);
        chk("t2_pos_wrap", data_out_w, 32'hBFBFBFBF);
        chk("t2_sat_cnt1", 32'(sat_count), 32'd1);
        chk("t2_sat_cnt_w", 32'(sat_count_w), 32'd0);
        do_pair(32'h80808080, 32'h80808080, 2'd0);
        chk("t2_neg_sat", data_out, 32'h80808080);
        chk("t2_neg_wrap", data_out_w, 32'h40404040);
        chk("t2_sat_cnt2", 32'(sat_count), 32'd2);

        // T3: modes
        do_pair(32'h10101010, 32'h04040404, 2'd1);
        chk("t3_sub", data_out, 32'h04040404);
        do_pair(32'h10101010, 32'h04040404, 2'd2);
        chk("t3_pass_skip", data_out, 32'h08080808);
        do_pair(32'h10101010, 32'h04040404, 2'd3);
        chk("t3_pass_mod", data_out, 32'h04040404);
        chk("t3_sat", 32'(sat_count), 32'd2);
        step();

        // T4: fill FIFO, hold 9th beat, then stream 20 beats through pointer wrap
        run_stream(20, 2'd2, 1'b0, 10);
        chk("t4_fifo_empty", 32'(fifo_count), 32'd0);

        // T5: random backpressure over 100 beats
        run_stream(100, 2'd0, 1'b1, 0);
        chk("t5_fifo_empty", 32'(fifo_count), 32'd0);

        // T6: reset with fifo_count 5 and a stalled output
        data_out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            data_in       = skip_word(k + 50);
            data_in_valid = 1'b1;
            step();
        end
        data_in_valid   = 1'b0;
        module_in       = mod_word(50);
        module_in_valid = 1'b1;
        mode            = 2'd0;
        step();
        module_in_valid = 1'b0;
        chk("t6_pre_fifo", 32'(fifo_count), 32'd5);
        chk("t6_pre_valid", 32'(data_out_valid), 32'd1);
        rst = 1'b1;
        step();
        chk("t6_valid", 32'(data_out_valid), 32'd0);
        chk("t6_data", data_out, 32'd0);
        chk("t6_fifo", 32'(fifo_count), 32'd0);
        chk("t6_sat", 32'(sat_count), 32'd0);
        chk("t6_in_ready", 32'(data_in_ready), 32'd0);
        chk("t6_mir", 32'(module_in_ready), 32'd0);
        rst = 1'b0;
        data_out_ready = 1'b1;
        step();
        do_pair(skip_word(7), mod_word(7), 2'd0);
        chk("t6_first_result", data_out, exp_word(7, 2'd0));
        step();
        chk("t6_drained", 32'(data_out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
